// File: rtl/nfca_tx_framer.sv
// NFC-A (ISO14443A, 106 kbps) PCD transmit framer: byte stream in, SOF/data/odd-parity/EOF bits out, one per tx_req.
// Optional CRC_A append (init 0x6363, reflected poly 0x8408) when NFCA_TX_CRC_EN is defined.
module nfca_tx_framer #(
    parameter int FRAME_GAP_REQS = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic [2:0] in_bits,
    input  logic       tx_req,
    output logic       tx_en,
    output logic       tx_bit,
    output logic       busy,
    output logic       tx_done,
    output logic       err_underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_DATA, S_PAR, S_CRC, S_EOF, S_GAP, S_DROP
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP_REQS - 1);

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  nbits_q, nbits_d;
    logic        par_q, par_d;
    logic        last_q, last_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        hold_last_q, hold_last_d;
    logic [2:0]  hold_bits_q, hold_bits_d;
    logic        last_acc_q, last_acc_d;
    logic [15:0] gap_q, gap_d;
    logic        act_q;
    logic        tx_en_q, tx_en_d;
    logic        tx_bit_q, tx_bit_d;
    logic        tx_done_q, tx_done_d;
    logic        err_q, err_d;
    logic        accept;

`ifdef NFCA_TX_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_hi_q, crc_hi_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
    endfunction
`endif

    // act_q keeps in_ready low while reset is asserted and for the first edge after.
    assign in_ready = act_q && ((state_q == S_DROP) ||
                                (!hold_vld_q && !last_acc_q && state_q != S_GAP));
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q inside {S_SOF, S_DATA, S_PAR, S_CRC, S_EOF}) ||
                      (state_q == S_IDLE && hold_vld_q);

    assign tx_en        = tx_en_q;
    assign tx_bit       = tx_bit_q;
    assign tx_done      = tx_done_q;
    assign err_underrun = err_q;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        nbits_d     = nbits_q;
        par_d       = par_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        hold_last_d = hold_last_q;
        hold_bits_d = hold_bits_q;
        last_acc_d  = last_acc_q;
        gap_d       = gap_q;
        tx_en_d     = tx_en_q;
        tx_bit_d    = tx_bit_q;
        tx_done_d   = 1'b0;
        err_d       = 1'b0;
`ifdef NFCA_TX_CRC_EN
        crc_d       = crc_q;
        crc_hi_d    = crc_hi_q;
`endif

        // Acceptance only ever fills an empty holding register, so it never collides with a load below.
        if (accept) begin
            if (state_q == S_DROP) begin
                if (in_last) state_d = S_IDLE;
            end else begin
                hold_d      = in_data;
                hold_vld_d  = 1'b1;
                hold_last_d = in_last;
                hold_bits_d = in_last ? in_bits : 3'd0;
                if (in_last) last_acc_d = 1'b1;
            end
        end

        if (tx_req) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_vld_q) begin
                        sh_d       = hold_q;
                        cnt_d      = 4'd0;
                        nbits_d    = (hold_bits_q == 3'd0) ? 4'd8 : {1'b0, hold_bits_q};
                        par_d      = ~^hold_q;
                        last_d     = hold_last_q;
                        hold_vld_d = 1'b0;
                        tx_en_d    = 1'b1;
                        tx_bit_d   = 1'b0;
                        state_d    = S_SOF;
`ifdef NFCA_TX_CRC_EN
                        crc_d      = 16'h6363;
`endif
                    end
                end
                S_SOF, S_DATA: begin
                    if (cnt_q < nbits_q) begin
                        tx_bit_d = sh_q[0];
                        sh_d     = {1'b0, sh_q[7:1]};
                        cnt_d    = cnt_q + 4'd1;
                        state_d  = S_DATA;
`ifdef NFCA_TX_CRC_EN
                        crc_d    = crc_step(crc_q, sh_q[0]);
`endif
                    end else if (nbits_q == 4'd8) begin
                        tx_bit_d = par_q;
                        state_d  = S_PAR;
                    end else begin
                        // Partial final byte: no parity, straight to EOF.
                        tx_bit_d = 1'b0;
                        state_d  = S_EOF;
                    end
                end
                S_PAR: begin
                    if (last_q) begin
`ifdef NFCA_TX_CRC_EN
                        tx_bit_d = crc_q[0];
                        sh_d     = {1'b0, crc_q[7:1]};
                        cnt_d    = 4'd1;
                        par_d    = ~^crc_q[7:0];
                        crc_hi_d = 1'b0;
                        state_d  = S_CRC;
`else
                        tx_bit_d = 1'b0;
                        state_d  = S_EOF;
`endif
                    end else if (hold_vld_q) begin
                        tx_bit_d   = hold_q[0];
                        sh_d       = {1'b0, hold_q[7:1]};
                        cnt_d      = 4'd1;
                        nbits_d    = (hold_bits_q == 3'd0) ? 4'd8 : {1'b0, hold_bits_q};
                        par_d      = ~^hold_q;
                        last_d     = hold_last_q;
                        hold_vld_d = 1'b0;
                        state_d    = S_DATA;
`ifdef NFCA_TX_CRC_EN
                        crc_d      = crc_step(crc_q, hold_q[0]);
`endif
                    end else begin
                        tx_en_d  = 1'b0;
                        tx_bit_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = S_DROP;
                    end
                end
`ifdef NFCA_TX_CRC_EN
                S_CRC: begin
                    // cnt 1..8 = data bits sent, 9 = parity sent.
                    if (cnt_q < 4'd8) begin
                        tx_bit_d = sh_q[0];
                        sh_d     = {1'b0, sh_q[7:1]};
                        cnt_d    = cnt_q + 4'd1;
                    end else if (cnt_q == 4'd8) begin
                        tx_bit_d = par_q;
                        cnt_d    = 4'd9;
                    end else if (!crc_hi_q) begin
                        tx_bit_d = crc_q[8];
                        sh_d     = {1'b0, crc_q[15:9]};
                        cnt_d    = 4'd1;
                        par_d    = ~^crc_q[15:8];
                        crc_hi_d = 1'b1;
                    end else begin
                        tx_bit_d = 1'b0;
                        state_d  = S_EOF;
                    end
                end
`endif
                S_EOF: begin
                    tx_en_d    = 1'b0;
                    tx_bit_d   = 1'b0;
                    tx_done_d  = 1'b1;
                    last_acc_d = 1'b0;
                    gap_d      = 16'd0;
                    state_d    = (FRAME_GAP_REQS == 0) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) state_d = S_IDLE;
                    else                   gap_d   = gap_q + 16'd1;
                end
                S_DROP: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            sh_q        <= 8'd0;
            cnt_q       <= 4'd0;
            nbits_q     <= 4'd0;
            par_q       <= 1'b0;
            last_q      <= 1'b0;
            hold_q      <= 8'd0;
            hold_vld_q  <= 1'b0;
            hold_last_q <= 1'b0;
            hold_bits_q <= 3'd0;
            last_acc_q  <= 1'b0;
            gap_q       <= 16'd0;
            act_q       <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_bit_q    <= 1'b0;
            tx_done_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef NFCA_TX_CRC_EN
            crc_q       <= 16'h6363;
            crc_hi_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            nbits_q     <= nbits_d;
            par_q       <= par_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            hold_last_q <= hold_last_d;
            hold_bits_q <= hold_bits_d;
            last_acc_q  <= last_acc_d;
            gap_q       <= gap_d;
            act_q       <= 1'b1;
            tx_en_q     <= tx_en_d;
            tx_bit_q    <= tx_bit_d;
            tx_done_q   <= tx_done_d;
            err_q       <= err_d;
`ifdef NFCA_TX_CRC_EN
            crc_q       <= crc_d;
            crc_hi_q    <= crc_hi_d;
`endif
        end
    end

endmodule

// File: doc/nfca_tx_framer.md
Name: nfca_tx_framer

Overview:
- Bit-level frame builder for the NFC-A (ISO14443A, 106 kbps) PCD transmit path.
- Accepts a byte stream from the controller and inserts SOF, per-byte odd parity and EOF.
- Serialises bits LSB first to the downstream Modified-Miller modulator, one bit per tx_req pulse.
- Sits directly upstream of the modulator, sharing its 81.36 MHz clock.

Parameters:
- FRAME_GAP_REQS, default 0: number of tx_req pulses after a frame ends during which a new frame must not start (tx_en held 0).

Ports:
- clk  in  1  81.36 MHz clock
- rstn  in  1  asynchronous active-low reset (0: reset, 1: work)
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_data  in  8  frame byte, transmitted LSB first
- in_last  in  1  last byte of frame
- in_bits  in  3  valid bits in last byte; 0 = full byte; ignored unless in_last
- tx_req  in  1  one-cycle pulse from modulator requesting the next bit
- tx_en  out  1  1 = tx_bit is a frame bit; 0 = no frame / end of frame
- tx_bit  out  1  bit value
- busy  out  1  frame in progress (first byte accepted through EOF issued)
- tx_done  out  1  one-cycle pulse when frame terminates normally
- err_underrun  out  1  one-cycle pulse when a frame aborts on byte starvation

Behaviour:
- Reset values: in_ready=0, tx_en=0, tx_bit=0, busy=0, tx_done=0, err_underrun=0. FSM goes to IDLE, holding register empty, gap counter 0.
- Output timing: tx_en and tx_bit are registered and update only on the clock edge after a cycle with tx_req=1. They hold stable between requests. The modulator samples them 2 cycles after tx_req.
- Storage: one shift register (current byte) plus one holding register (prefetch).
  - in_ready=1 when the holding register is empty, in_last has not yet been accepted for the current frame, and the FSM is not in GAP.
- FSM states: IDLE, SOF, DATA, PAR, CRC (optional), EOF, GAP, DROP.
  - IDLE: tx_en=0. On tx_req with a byte held, move it to the shift register, output tx_en=1 / tx_bit=0 (SOF), and go to DATA. tx_req with nothing held: outputs unchanged.
  - DATA: each tx_req shifts out the next bit LSB first.
    - Full byte: after bit 7, the next tx_req emits odd parity (~^byte) and enters PAR.
    - Last byte with in_bits=N≠0: only N bits are sent, no parity, then go to EOF.
  - PAR: on the next tx_req, in priority order:
    - if the byte was the last one, emit EOF bit 0 and enter EOF;
    - else if the holding register is full, load it and emit its bit 0;
    - else abort: tx_en=0, pulse err_underrun, enter DROP.
  - EOF: the next tx_req drives tx_en=0, pulses tx_done and enters GAP.
  - GAP: counts FRAME_GAP_REQS tx_req pulses, then goes to IDLE. With FRAME_GAP_REQS=0, go straight to IDLE.
  - DROP: in_ready=1; discard bytes until a byte with in_last is accepted, then go to IDLE. busy=0 in DROP.
- Every frame bit sequence is: SOF(0), data/parity bits, EOF(0), then tx_en=0.
- Simultaneous events:
  - Byte acceptance and tx_req in the same cycle: the tx_req action uses the pre-edge holding state.
  - A byte accepted that cycle is available from the next tx_req.
- Reset mid-frame: all state cleared asynchronously, tx_en=0 immediately. Partially accepted frame bytes are lost.

Optional Feature:
- Macro NFCA_TX_CRC_EN.
- Defined:
  - CRC_A is computed over all data bytes (init 0x6363, reflected poly 0x8408, LSB first).
  - For frames whose last byte is full (in_bits=0), after that byte's parity the framer sends CRC low byte then high byte, each with odd parity, then EOF.
  - Frames ending in a partial byte get no CRC.
- Undefined: no CRC logic; frames are exactly the supplied bytes.

Test Plan:
- REQA: 0x26, in_last=1, in_bits=7 -> bits with tx_en=1: 0 | 0,1,1,0,0,1,0 | 0, then tx_en=0 and tx_done pulse; no parity bit.
- 0x50 full byte, single-byte frame -> 0 | 0,0,0,0,1,0,1,0 | parity 1 | EOF 0; 11 tx_en=1 bits total.
- Two-byte frame 0x93,0x20 presented late (second byte arrives after first byte's bit 3 request) -> seamless, no gap, parities 1 and 0.
- Underrun: first byte without in_last, second withheld past parity request -> tx_en=0, err_underrun pulse, busy=0. The late bytes through in_last are consumed with no tx output.
- NFCA_TX_CRC_EN: HLTA 0x50,0x00 -> CRC bytes 0x57 then 0xCD appended, each with parity (0x57 parity 0, 0xCD parity 0).
- FRAME_GAP_REQS=3, back-to-back frames -> exactly 3 tx_req pulses with tx_en=0 between the first frame's tx_done and the second SOF. Also assert rstn mid-DATA -> tx_en=0 at once.
